// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master (instruction fetch / data) to three-slave (BRAM, UART, timer)
//   bus arbiter. A single transaction is in flight at a time. Contention in
//   IDLE is resolved round-robin. The granted request is latched, so the
//   broadcast m_* fields stay stable while the addressed slave is busy. An
//   unmapped address gets an error response and no slave sees a valid.
//
// Optional feature: define ARBITER_TIMEOUT_EN to add a watchdog. A slave that
//   has not answered within timeout_cycles BUSY cycles is abandoned, and the
//   requester receives an error response.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_valid, i_addr                 instruction read request
//   i_rdata, i_ready, i_error       instruction response (one-cycle pulse)
//   d_valid, d_addr, d_wdata,
//   d_wstrb                         data request (d_wstrb == 0 means read)
//   d_rdata, d_ready, d_error       data response (one-cycle pulse)
//   m_addr, m_wdata, m_wstrb        broadcast fields of the granted request
//   bram_/uart_/timer_ valid,
//   rdata, ready                    slave handshakes
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int          bram_depth         = 12,
  parameter logic [31:0] start_base_addr    = 32'h0000_0000,
  parameter logic [31:0] uart_base_addr     = 32'h0010_0000,
  parameter logic [31:0] uart_top_addr      = 32'h0010_0004,
  parameter logic [31:0] timer_base_address = 32'h0020_0000,
  parameter logic [31:0] timer_top_address  = 32'h0020_0010,
  parameter int          timeout_cycles     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_error,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_error,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        bram_valid,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,
  output logic        uart_valid,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready,
  output logic        timer_valid,
  input  logic [31:0] timer_rdata,
  input  logic        timer_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    ERR_I  = 3'd3,
    ERR_D  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0]  SEL_BRAM  = 2'd0;
  localparam logic [1:0]  SEL_UART  = 2'd1;
  localparam logic [1:0]  SEL_TIMER = 2'd2;
  localparam logic [1:0]  SEL_NONE  = 2'd3;
  localparam logic [32:0] BRAM_SIZE = 33'd1 << (bram_depth + 2);

  // BRAM test uses a 33-bit offset so an address below the base wraps to a
  // huge value and fails the size compare; no 32-bit overflow at the top.
  function automatic logic [1:0] decode_addr(input logic [31:0] addr);
    logic [1:0] sel;
    if (({1'b0, addr} - {1'b0, start_base_addr}) < BRAM_SIZE) begin
      sel = SEL_BRAM;
    end else if (addr >= uart_base_addr && addr < uart_top_addr) begin
      sel = SEL_UART;
    end else if (addr >= timer_base_address && addr < timer_top_address) begin
      sel = SEL_TIMER;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant_d;  // 1: data was granted last
  logic [1:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bram_valid;
  logic        r_uart_valid;
  logic        r_timer_valid;
  logic [31:0] r_i_rdata;
  logic        r_i_ready;
  logic        r_i_error;
  logic [31:0] r_d_rdata;
  logic        r_d_ready;
  logic        r_d_error;

  logic        w_take;
  logic        w_grant_d;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_sel;
  logic [1:0]  w_sel_nxt;
  logic        w_busy_nxt;
  logic        w_slave_ready;
  logic [31:0] w_slave_rdata;
  logic        w_timeout;
  logic        w_resp_i;
  logic        w_resp_d;
  logic        w_resp_err;
  logic [31:0] w_resp_rdata;

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(timeout_cycles - 1);
  logic [15:0] r_wdog;

  // Watchdog: zero outside BUSY, counts each BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 16'd0;
    end else if (r_state == BUSY_I || r_state == BUSY_D) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= 16'd0;
    end
  end

  assign w_timeout = (r_wdog == WDOG_LIMIT);
`else
  logic w_unused;
  assign w_unused  = (timeout_cycles != 0);
  assign w_timeout = 1'b0;
`endif

  // Only the latched slave's ready/rdata are looked at; others are ignored.
  always_comb begin
    w_slave_ready = 1'b0;
    w_slave_rdata = 32'h0;
    case (r_sel)
      SEL_BRAM:  begin w_slave_ready = bram_ready;  w_slave_rdata = bram_rdata;  end
      SEL_UART:  begin w_slave_ready = uart_ready;  w_slave_rdata = uart_rdata;  end
      SEL_TIMER: begin w_slave_ready = timer_ready; w_slave_rdata = timer_rdata; end
      default:   begin w_slave_ready = 1'b0;        w_slave_rdata = 32'h0;       end
    endcase
  end

  // Next-state logic, including the round-robin grant decision in IDLE.
  always_comb begin
    w_take      = 1'b0;
    w_grant_d   = 1'b0;
    w_req_addr  = i_addr;
    w_req_sel   = SEL_NONE;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_take = i_valid | d_valid;
        if (i_valid && d_valid) begin
          w_grant_d = ~r_last_grant_d;
        end else begin
          w_grant_d = d_valid;
        end
        w_req_addr = w_grant_d ? d_addr : i_addr;
        w_req_sel  = decode_addr(w_req_addr);
        if (!w_take) begin
          w_state_nxt = IDLE;
        end else if (w_req_sel == SEL_NONE) begin
          w_state_nxt = w_grant_d ? ERR_D : ERR_I;
        end else begin
          w_state_nxt = w_grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_slave_ready || w_timeout) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ERR_I, ERR_D: w_state_nxt = DONE;
      DONE:         w_state_nxt = IDLE;
      default:      w_state_nxt = IDLE;
    endcase
  end

  // Response and slave-select values for the next edge.
  always_comb begin
    if (r_state == IDLE) begin
      w_sel_nxt = w_req_sel;
    end else begin
      w_sel_nxt = r_sel;
    end
    w_busy_nxt   = (w_state_nxt == BUSY_I) || (w_state_nxt == BUSY_D);
    w_resp_i     = (r_state == ERR_I) || ((r_state == BUSY_I) && (w_slave_ready || w_timeout));
    w_resp_d     = (r_state == ERR_D) || ((r_state == BUSY_D) && (w_slave_ready || w_timeout));
    w_resp_err   = !(((r_state == BUSY_I) || (r_state == BUSY_D)) && w_slave_ready);
    w_resp_rdata = w_resp_err ? 32'h0 : w_slave_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, slave valids and one-cycle response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_d <= 1'b0;
      r_sel          <= SEL_NONE;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_wstrb        <= 4'h0;
      r_bram_valid   <= 1'b0;
      r_uart_valid   <= 1'b0;
      r_timer_valid  <= 1'b0;
      r_i_rdata      <= 32'h0;
      r_i_ready      <= 1'b0;
      r_i_error      <= 1'b0;
      r_d_rdata      <= 32'h0;
      r_d_ready      <= 1'b0;
      r_d_error      <= 1'b0;
    end else begin
      if (r_state == IDLE && w_take) begin
        r_last_grant_d <= w_grant_d;
        r_sel          <= w_req_sel;
        r_addr         <= w_req_addr;
        r_wdata        <= w_grant_d ? d_wdata : 32'h0;
        r_wstrb        <= w_grant_d ? d_wstrb : 4'h0;
      end
      r_bram_valid  <= w_busy_nxt && (w_sel_nxt == SEL_BRAM);
      r_uart_valid  <= w_busy_nxt && (w_sel_nxt == SEL_UART);
      r_timer_valid <= w_busy_nxt && (w_sel_nxt == SEL_TIMER);
      r_i_ready     <= w_resp_i;
      r_i_error     <= w_resp_i && w_resp_err;
      r_d_ready     <= w_resp_d;
      r_d_error     <= w_resp_d && w_resp_err;
      if (w_resp_i) begin
        r_i_rdata <= w_resp_rdata;
      end
      if (w_resp_d) begin
        r_d_rdata <= w_resp_rdata;
      end
    end
  end

  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign m_wstrb     = r_wstrb;
  assign bram_valid  = r_bram_valid;
  assign uart_valid  = r_uart_valid;
  assign timer_valid = r_timer_valid;
  assign i_rdata     = r_i_rdata;
  assign i_ready     = r_i_ready;
  assign i_error     = r_i_error;
  assign d_rdata     = r_d_rdata;
  assign d_ready     = r_d_ready;
  assign d_error     = r_d_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected responses (order
// from a round-robin model, data from behavioural slave models); a monitor
// pops and compares on every i_ready/d_ready and checks the slave selection.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_error;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_wstrb = 4'h0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_error;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        bram_valid, uart_valid, timer_valid;
  logic        bram_ready, uart_ready, timer_ready;
  logic [31:0] bram_rdata, uart_rdata, timer_rdata;

  logic [2:0]  sv;
  logic [2:0]  srdy = 3'b000;
  logic [31:0] srd [3];

  assign sv          = {timer_valid, uart_valid, bram_valid};
  assign bram_ready  = srdy[0];
  assign uart_ready  = srdy[1];
  assign timer_ready = srdy[2];
  assign bram_rdata  = srd[0];
  assign uart_rdata  = srd[1];
  assign timer_rdata = srd[2];

  bus_arbiter #(.timeout_cycles(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_error(i_error),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .bram_valid(bram_valid), .bram_rdata(bram_rdata), .bram_ready(bram_ready),
    .uart_valid(uart_valid), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .timer_valid(timer_valid), .timer_rdata(timer_rdata), .timer_ready(timer_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          slave;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          drv_cyc = 0;
  int          last_i_cyc = 0;
  int          last_d_cyc = 0;
  int          vcount = 0;
  int          force_wait = -1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;
  bit          model_last_d = 1'b0;
  int          scnt [3];
  int          swait [3];

  function automatic logic [31:0] slave_word(input int s, input logic [31:0] a);
    return a ^ 32'h0000_5A5A ^ (32'hB000_0000 + (32'(s) << 24));
  endfunction

  // Memory map as a plain table of address ranges.
  function automatic int model_slave(input logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h0010_0000 && a < 32'h0010_0004) return 1;
    if (a >= 32'h0020_0000 && a < 32'h0020_0010) return 2;
    return 3;
  endfunction

  function automatic exp_t make_exp(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] ws, input bit tmo);
    exp_t e;
    e.is_d  = is_d;
    e.addr  = a;
    e.wdata = wd;
    e.wstrb = is_d ? ws : 4'h0;
    e.slave = model_slave(a);
    e.err   = (e.slave == 3) || tmo;
    e.rdata = e.err ? 32'h0 : (ovr_en ? ovr_val : slave_word(e.slave, a));
    return e;
  endfunction

  function automatic logic [31:0] pick_addr();
    int k;
    k = int'($urandom_range(0, 12));
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0004;
      2:       return 32'h0000_3FFC;
      3:       return 32'h0000_4000;
      4:       return 32'h0010_0000;
      5:       return 32'h0010_0004;
      6:       return 32'h0020_0000;
      7:       return 32'h0020_000C;
      8:       return 32'h0020_0010;
      9:       return 32'h0030_0000;
      10:      return 32'hFFFF_FFFC;
      11:      return 32'h000F_FFFF;
      default: return {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
    endcase
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_vec({name, "_data"}, {i_rdata, d_rdata, m_addr, m_wdata}, 128'h0);
    check_vec({name, "_ctrl"}, {117'd0, i_ready, d_ready, i_error, d_error,
                                bram_valid, uart_valid, timer_valid, m_wstrb}, 128'h0);
  endtask

  // Issue one round (instr, data or both), queue expectations in the order the
  // round-robin rule serves them, then drop each valid once its ready is seen.
  task automatic run_round(input bit ui, input bit ud, input logic [31:0] ai, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] ws, input bit tmo);
    exp_t ei, ed;
    ei = make_exp(1'b0, ai, 32'h0, 4'h0, tmo);
    ed = make_exp(1'b1, ad, wd, ws, tmo);
    if (ui && ud) begin
      if (!model_last_d) begin
        exp_q.push_back(ed); exp_q.push_back(ei); model_last_d = 1'b0;
      end else begin
        exp_q.push_back(ei); exp_q.push_back(ed); model_last_d = 1'b1;
      end
    end else if (ud) begin
      exp_q.push_back(ed); model_last_d = 1'b1;
    end else if (ui) begin
      exp_q.push_back(ei); model_last_d = 1'b0;
    end
    @(posedge clk); #1;
    i_valid = ui; i_addr = ai;
    d_valid = ud; d_addr = ad; d_wdata = wd; d_wstrb = ws;
    drv_cyc = cyc;
    vcount  = 0;
    for (int n = 0; n < 200 && (i_valid || d_valid); n++) begin
      @(posedge clk); #1;
      if (i_valid && i_ready) i_valid = 1'b0;
      if (d_valid && d_ready) d_valid = 1'b0;
    end
    if (i_valid || d_valid) begin
      checks++; failures++;
      $display("FAIL round_timeout i_valid=%0b d_valid=%0b still pending", i_valid, d_valid);
      i_valid = 1'b0; d_valid = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave models: wait force_wait (or random 0..3) cycles, then answer; while
  // unselected they toggle ready with junk data that must be ignored.
  initial begin
    for (int s = 0; s < 3; s++) begin
      srd[s] = 32'h0; scnt[s] = 0; swait[s] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        if (sv[s]) begin
          if (scnt[s] == 0) swait[s] = (force_wait < 0) ? int'($urandom_range(0, 3)) : force_wait;
          if (scnt[s] >= swait[s]) begin
            srdy[s] = 1'b1;
            srd[s]  = ovr_en ? ovr_val : slave_word(s, m_addr);
          end else begin
            srdy[s] = 1'b0;
            srd[s]  = $urandom;
          end
          scnt[s]++;
        end else begin
          scnt[s] = 0;
          srdy[s] = ($urandom_range(0, 3) == 0);
          srd[s]  = $urandom;
        end
      end
    end
  end

  // Monitor: slave selection / broadcast fields, then responses vs. scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (sv != 3'b000) begin
        vcount++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL slave_valid_unexpected sv=%0b", sv);
        end else begin
          mon_e = exp_q[0];
          if (sv != (3'b001 << mon_e.slave) || m_addr != mon_e.addr || m_wstrb != mon_e.wstrb ||
              (mon_e.is_d && m_wdata != mon_e.wdata)) begin
            failures++;
            $display("FAIL slave_select actual sv=%0b addr=%0h wstrb=%0h wdata=%0h expected slave=%0d addr=%0h wstrb=%0h wdata=%0h",
                     sv, m_addr, m_wstrb, m_wdata, mon_e.slave, mon_e.addr, mon_e.wstrb, mon_e.wdata);
          end
        end
      end
      if (i_ready || d_ready) begin
        checks++;
        if (d_ready) last_d_cyc = cyc; else last_i_cyc = cyc;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL response_unexpected i_ready=%0b d_ready=%0b", i_ready, d_ready);
        end else begin
          mon_e = exp_q.pop_front();
          if ((i_ready && d_ready) || (mon_e.is_d ? !d_ready : !i_ready) ||
              (d_ready ? d_rdata : i_rdata) != mon_e.rdata ||
              (d_ready ? d_error : i_error) != mon_e.err) begin
            failures++;
            $display("FAIL response actual i_ready=%0b d_ready=%0b i=%0h/%0b d=%0h/%0b expected is_d=%0b rdata=%0h err=%0b",
                     i_ready, d_ready, i_rdata, i_error, d_rdata, d_error, mon_e.is_d, mon_e.rdata, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

`ifdef ARBITER_TIMEOUT_EN
  localparam int HANG_CYC = 5;
`else
  localparam int HANG_CYC = 1000;
`endif

  initial begin
    bit          ui, ud;
    logic [31:0] ai, ad, wd;
    logic [3:0]  ws;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Contention after reset: data first, then alternate.
    force_wait = 0;
    run_round(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    run_round(1'b1, 1'b1, 32'h4, 32'h8, 32'h0, 4'h0, 1'b0);

    // UART write, zero-wait.
    run_round(1'b0, 1'b1, 32'h0, 32'h0010_0000, 32'h41, 4'h1, 1'b0);
    check_int("uart_wr_latency", last_d_cyc - drv_cyc, 2);
    check_int("uart_wr_valid_cycles", vcount, 1);

    // Unmapped instruction fetch.
    run_round(1'b1, 1'b0, 32'h0030_0000, 32'h0, 32'h0, 4'h0, 1'b0);
    check_int("unmapped_latency", last_i_cyc - drv_cyc, 2);
    check_int("unmapped_valid_cycles", vcount, 0);

    // Timer read with three wait cycles, then just past the timer top.
    force_wait = 3; ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    run_round(1'b0, 1'b1, 32'h0, 32'h0020_0008, 32'h0, 4'h0, 1'b0);
    check_int("timer_wait_latency", last_d_cyc - drv_cyc, 5);
    check_int("timer_wait_valid_cycles", vcount, 4);
    ovr_en = 1'b0;
    run_round(1'b0, 1'b1, 32'h0, 32'h0020_0010, 32'h0, 4'h0, 1'b0);

    // Randomised rounds.
    force_wait = -1;
    for (int r = 0; r < 80; r++) begin
      ui = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!ui && !ud) ud = 1'b1;
      ai = pick_addr();
      ad = pick_addr();
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      run_round(ui, ud, ai, ad, wd, ws, 1'b0);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
    end

    force_wait = 1000000;
`ifdef ARBITER_TIMEOUT_EN
    run_round(1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 4'h0, 1'b1);
    check_int("timeout_valid_cycles", vcount, 16);
`endif

    // Stuck BRAM fetch, then reset in the middle of it.
    exp_q.push_back(make_exp(1'b0, 32'h80, 32'h0, 4'h0, 1'b0));
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = 32'h80;
    for (int n = 0; n < 10 && !bram_valid; n++) @(posedge clk);
    repeat (HANG_CYC) @(posedge clk);
    #1;
    check_int("hang_bram_valid", int'(bram_valid), 1);
    #2;
    rst_n = 1'b0; i_valid = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    model_last_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_wait = 0;
    run_round(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);

    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
